dmem_responder: RTL and testbench

Data-side memory responder for the 16-bit RISC core. It answers the load/store requests that the datapath issues (address from the ALU, store data from register port 2, read/write strobes) through a valid/ready request channel and a one-cycle response pulse. Latency is a fixed, configurable number of wait states. The block holds word-organised storage, checks address alignment and range, and keeps a completed-transaction counter for performance monitoring.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Data-side memory responder for the 16-bit RISC core. Each load or store is
// accepted through a valid/ready request channel. After WAIT_CYCLES wait
// states the block issues a one-cycle response pulse. Storage is a
// word-organised array of 16-bit words. Every request is checked for
// alignment and range before it can touch memory. A wrapping counter records
// each successful transaction.
//
// Parameters
//   DEPTH_WORDS  number of 16-bit words (power of two, 2..32768)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk        in   single clock, rising-edge
//   reset      in   synchronous active-high reset; clears state, outputs, memory
//   req_valid  in   request present
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (word aligned)
//   req_wdata  in   store data
//   req_ready  out  request can be accepted this cycle
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data, held between responses
//   rsp_err    out  request rejected (qualified by rsp_valid)
//   txn_count  out  count of successful responses, wraps

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] txn_count
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [16:0] ADDR_LIMIT = 17'(2 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]    wait_cnt;
  logic          write_p0;
  logic          err_p0;
  logic [AW-1:0] idx_p0;
  logic [15:0]   wdata_p0;

  logic [15:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          addr_err;
  logic          cur_write;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic          enter_resp;

  // Misaligned addresses and addresses past the end of the array are rejected.
  // The upper-bound compare is done in 17 bits so that the largest depth works.
  assign addr_err = req_addr[0] | ({1'b0, req_addr} >= ADDR_LIMIT);
  assign accept   = req_valid && (state == S_IDLE);

  // With zero wait states, RESP is entered on the same edge that accepts the
  // request. The captured copy does not exist yet on that edge, so the read
  // path uses the live request fields while in IDLE.
  always_comb begin
    cur_write = write_p0;
    cur_err   = err_p0;
    cur_idx   = idx_p0;
    if (state == S_IDLE) begin
      cur_write = req_write;
      cur_err   = addr_err;
      cur_idx   = req_addr[AW:1];
    end
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_cnt == 4'd0) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs decoded from state ----
  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // ---- stage p0: request capture and wait counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      write_p0 <= 1'b0;
      err_p0   <= 1'b0;
      idx_p0   <= '0;
      wdata_p0 <= 16'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
      write_p0 <= req_write;
      err_p0   <= addr_err;
      idx_p0   <= req_addr[AW:1];
      wdata_p0 <= req_wdata;
    end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ---- stage p1: response registers and transaction counter ----
  // Because reset has priority, a request that is pending in WAIT or RESP
  // is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
      txn_count <= 16'd0;
    end else begin
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur_write) ? 16'd0 : mem[cur_idx];
      end
      if ((state == S_RESP) && !err_p0)
        txn_count <= txn_count + 16'd1;
    end
  end

  // Store commit happens on the edge that leaves RESP. A load that follows
  // therefore always sees the new data, and no bypass path is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 16'd0;
    end else if ((state == S_RESP) && write_p0 && !err_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. It uses two instances. The first has
// WAIT_CYCLES=2 and covers the main scenarios. The second has WAIT_CYCLES=0
// and covers back-to-back traffic and counter wrap. Inputs change on the
// falling edge, and outputs are sampled on the falling edge.

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = 16'd0, req_wdata = 16'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata, txn_count;

  logic        v0 = 1'b0, w0 = 1'b0;
  logic [15:0] a0 = 16'd0, d0 = 16'd0;
  logic        rdy0, rv0, er0;
  logic [15:0] rd0, tc0;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_txn = 16'd0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .txn_count(txn_count)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .req_ready(rdy0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0),
    .txn_count(tc0)
  );

  // Issues one request to the WAIT_CYCLES=2 instance. It must be entered on a
  // falling edge while the DUT is idle. It returns on the falling edge after
  // the response cycle. lat counts the falling-edge samples after the accept
  // edge up to and including the one where rsp_valid was seen. A value of 99
  // means no response was seen.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 16'd0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = 99;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] rd; logic er; int lat;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_txn = 16'd0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL reset_txn: got %h expected 0000", txn_count); end
    total++; if (rsp_rdata !== 16'd0) begin bad++; $display("FAIL reset_rdata: got %h expected 0000", rsp_rdata); end
    total++; if (rdy0 !== 1'b1 || tc0 !== 16'd0) begin bad++; $display("FAIL reset_w0: got ready=%b txn=%h expected ready=1 txn=0000", rdy0, tc0); end
    do_req(1'b0, 16'h0010, 16'd0, rd, er, lat);
    exp_txn++;
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_load_data: got %h expected 0000", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL reset_load_err: got %b expected 0", er); end
    total++; if (lat !== 3) begin bad++; $display("FAIL reset_load_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_store_load;
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 16'h0004, 16'hBEEF, rd, er, lat);
    exp_txn++;
    total++; if (lat !== 3) begin bad++; $display("FAIL store_lat: got %0d expected 3", lat); end
    total++; if (er !== 1'b0 || rd !== 16'h0000) begin bad++; $display("FAIL store_rsp: got err=%b data=%h expected err=0 data=0000", er, rd); end
    do_req(1'b0, 16'h0004, 16'd0, rd, er, lat);
    exp_txn++;
    total++; if (lat !== 3) begin bad++; $display("FAIL load_lat: got %0d expected 3", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL load_data: got %h expected beef", rd); end
    total++; if (txn_count !== exp_txn) begin bad++; $display("FAIL store_load_txn: got %h expected %h", txn_count, exp_txn); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL pulse_width: got rsp_valid=%b expected 0", rsp_valid); end
    repeat (3) @(negedge clk);
    total++; if (rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL rdata_hold: got %h expected beef", rsp_rdata); end
  endtask

  task automatic test_misaligned;
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 16'h0005, 16'h1234, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL misalign_rsp: got err=%b data=%h expected err=1 data=0000", er, rd); end
    total++; if (txn_count !== exp_txn) begin bad++; $display("FAIL misalign_txn: got %h expected %h", txn_count, exp_txn); end
    do_req(1'b0, 16'h0004, 16'd0, rd, er, lat);
    exp_txn++;
    total++; if (rd !== 16'hBEEF || er !== 1'b0) begin bad++; $display("FAIL misalign_load: got err=%b data=%h expected err=0 data=beef", er, rd); end
  endtask

  task automatic test_range;
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 16'h01FE, 16'h5A5A, rd, er, lat);
    exp_txn++;
    do_req(1'b1, 16'h0200, 16'h7777, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL range_store_err: got %b expected 1", er); end
    do_req(1'b0, 16'h0200, 16'd0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL range_load: got err=%b data=%h expected err=1 data=0000", er, rd); end
    total++; if (txn_count !== exp_txn) begin bad++; $display("FAIL range_txn: got %h expected %h", txn_count, exp_txn); end
    do_req(1'b0, 16'h01FE, 16'd0, rd, er, lat);
    exp_txn++;
    total++; if (er !== 1'b0 || rd !== 16'h5A5A) begin bad++; $display("FAIL boundary_load: got err=%b data=%h expected err=0 data=5a5a", er, rd); end
    do_req(1'b0, 16'h0000, 16'd0, rd, er, lat);
    exp_txn++;
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL range_alias: got %h expected 0000", rd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    logic        odd;
    force dut0.txn_count = 16'hFFFF;
    #1;
    release dut0.txn_count;
    @(negedge clk);
    total++; if (tc0 !== 16'hFFFF) begin bad++; $display("FAIL b2b_preset: got %h expected ffff", tc0); end
    v0 = 1'b1; w0 = 1'b1; a0 = 16'h0002; d0 = 16'h1111;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      odd = (k % 2) == 1;
      e = 16'hFFFF + 16'(k / 2);
      total++; if (rv0 !== odd) begin bad++; $display("FAIL b2b_valid_%0d: got %b expected %b", k, rv0, odd); end
      total++; if (rdy0 !== !odd) begin bad++; $display("FAIL b2b_ready_%0d: got %b expected %b", k, rdy0, !odd); end
      total++; if (tc0 !== e) begin bad++; $display("FAIL b2b_txn_%0d: got %h expected %h", k, tc0, e); end
    end
    v0 = 1'b0; w0 = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    total++; if (rv0 !== 1'b1 || rd0 !== 16'h1111 || er0 !== 1'b0) begin bad++; $display("FAIL b2b_load: got valid=%b data=%h err=%b expected valid=1 data=1111 err=0", rv0, rd0, er0); end
    @(negedge clk);
    total++; if (tc0 !== 16'h0003) begin bad++; $display("FAIL b2b_final_txn: got %h expected 0003", tc0); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; logic er; int lat;
    logic seen;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0008; req_wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_rsp: got rsp_valid seen=%b expected 0", seen); end
    total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL midreset_txn: got %h expected 0000", txn_count); end
    exp_txn = 16'd0;
    do_req(1'b0, 16'h0008, 16'd0, rd, er, lat);
    total++; if (rd !== 16'h0000 || er !== 1'b0) begin bad++; $display("FAIL midreset_load: got err=%b data=%h expected err=0 data=0000", er, rd); end
    do_req(1'b0, 16'h0004, 16'd0, rd, er, lat);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midreset_cleared: got %h expected 0000", rd); end
    // Reset on the same edge that would commit the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h000A; req_wdata = 16'hCCCC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL exitreset_reach: got rsp_valid=%b expected 1", rsp_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (txn_count !== 16'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL exitreset_state: got txn=%h valid=%b expected txn=0000 valid=0", txn_count, rsp_valid); end
    do_req(1'b0, 16'h000A, 16'd0, rd, er, lat);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL exitreset_load: got %h expected 0000", rd); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_misaligned;
    test_range;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
